// File: rtl/forward_producer_if.sv
// forward_producer_if -- bundle between the pipeline control and the forwarding
// producer.
//   master : drives issue/result/stall/flush, observes the forward and WB ports
//   slave  : forward_producer itself
// Issue side : issue, issueDestReg, issueReadyStage, issueValue
// Results    : execResult (instruction in E), memResult (instruction in M)
// Control    : stall, flush
// Forward    : src1* (E, highest priority), src2* (M), src3* (W, lowest)
// Write-back : wbEnable, wbReg, wbValue
interface forward_producer_if #(
  parameter int WIDTH = 32
);
  logic             issue;
  logic [4:0]       issueDestReg;
  logic [1:0]       issueReadyStage;
  logic [WIDTH-1:0] issueValue;
  logic [WIDTH-1:0] execResult;
  logic [WIDTH-1:0] memResult;
  logic             stall;
  logic             flush;

  logic             src1Valid, src2Valid, src3Valid;
  logic [4:0]       src1Reg, src2Reg, src3Reg;
  logic [WIDTH-1:0] src1Value, src2Value, src3Value;

  logic             wbEnable;
  logic [4:0]       wbReg;
  logic [WIDTH-1:0] wbValue;

  modport master (
    output issue, issueDestReg, issueReadyStage, issueValue,
           execResult, memResult, stall, flush,
    input  src1Valid, src1Reg, src1Value,
           src2Valid, src2Reg, src2Value,
           src3Valid, src3Reg, src3Value,
           wbEnable, wbReg, wbValue
  );

  modport slave (
    input  issue, issueDestReg, issueReadyStage, issueValue,
           execResult, memResult, stall, flush,
    output src1Valid, src1Reg, src1Value,
           src2Valid, src2Reg, src2Value,
           src3Valid, src3Reg, src3Value,
           wbEnable, wbReg, wbValue
  );
endinterface

// File: rtl/forward_producer.sv
// forward_producer -- tracks the destination register and result of the
// instructions in E, M and W and publishes them as bypass sources plus the
// register-file write port.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset, all stages become bubbles
//   bus   : forward_producer_if.slave (issue, results, stall/flush in;
//           src1..3 forward ports and wb port out)
// Every output is a function of the stage registers only.

// One forward port. A stage at index STAGE (E=0, M=1, W=2) can supply a value
// once its ready stage has been reached. The bubble encoding also has ready=0,
// so a non-zero register qualifies validity to keep bubbles invisible.
module forward_producer_port #(
  parameter int WIDTH = 32,
  parameter int STAGE = 0
) (
  input  logic [4:0]       rg_i,
  input  logic [1:0]       rdy_i,
  input  logic [WIDTH-1:0] val_i,
  output logic             valid_o,
  output logic [4:0]       reg_o,
  output logic [WIDTH-1:0] value_o
);
  assign valid_o = (rg_i != 5'd0) && (rdy_i <= 2'(STAGE));
  assign reg_o   = rg_i;
  assign value_o = valid_o ? val_i : '0;
endmodule

module forward_producer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  forward_producer_if.slave bus
);
  localparam int STAGES = 3;

  typedef struct packed {
    logic [4:0]       rg;
    logic [1:0]       rdy;
    logic [WIDTH-1:0] val;
  } entry_t;

  entry_t e_q, e_d, m_q, m_d, w_q, w_d;

  // E: flush beats stall beats issue; a zero destination loads a bubble.
  always_comb begin
    e_d = '0;
    if (bus.flush) begin
      e_d = '0;
    end else if (bus.stall) begin
      e_d = e_q;
    end else if (bus.issue && (bus.issueDestReg != 5'd0)) begin
      e_d.rg  = bus.issueDestReg;
      e_d.rdy = bus.issueReadyStage;
      e_d.val = (bus.issueReadyStage == 2'd0) ? bus.issueValue : '0;
    end
  end

  // M: a stall leaves E in place, so M receives a bubble. The E result is
  // captured here for ALU-type entries.
  always_comb begin
    m_d = '0;
    if (!bus.stall) begin
      m_d.rg  = e_q.rg;
      m_d.rdy = e_q.rdy;
      case (e_q.rdy)
        2'd0:    m_d.val = e_q.val;
        2'd1:    m_d.val = bus.execResult;
        default: m_d.val = '0;
      endcase
    end
  end

  // W: never stalls; load results are captured on the way out of M.
  always_comb begin
    w_d     = m_q;
    w_d.val = (m_q.rdy == 2'd2) ? bus.memResult : m_q.val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  logic [STAGES-1:0][4:0]       st_reg;
  logic [STAGES-1:0][1:0]       st_rdy;
  logic [STAGES-1:0][WIDTH-1:0] st_val;
  logic [STAGES-1:0]            fwd_vld;
  logic [STAGES-1:0][4:0]       fwd_reg;
  logic [STAGES-1:0][WIDTH-1:0] fwd_val;

  assign st_reg = {w_q.rg,  m_q.rg,  e_q.rg};
  assign st_rdy = {w_q.rdy, m_q.rdy, e_q.rdy};
  assign st_val = {w_q.val, m_q.val, e_q.val};

  for (genvar s = 0; s < STAGES; s++) begin : g_port
    forward_producer_port #(.WIDTH(WIDTH), .STAGE(s)) u_port (
      .rg_i    (st_reg[s]),
      .rdy_i   (st_rdy[s]),
      .val_i   (st_val[s]),
      .valid_o (fwd_vld[s]),
      .reg_o   (fwd_reg[s]),
      .value_o (fwd_val[s])
    );
  end

  assign bus.src1Valid = fwd_vld[0];
  assign bus.src1Reg   = fwd_reg[0];
  assign bus.src1Value = fwd_val[0];
  assign bus.src2Valid = fwd_vld[1];
  assign bus.src2Reg   = fwd_reg[1];
  assign bus.src2Value = fwd_val[1];
  assign bus.src3Valid = fwd_vld[2];
  assign bus.src3Reg   = fwd_reg[2];
  assign bus.src3Value = fwd_val[2];

  // W validity already implies a non-zero register and ready <= 2.
  assign bus.wbEnable = fwd_vld[2];
  assign bus.wbReg    = w_q.rg;
  assign bus.wbValue  = w_q.val;
endmodule

// File: tb/tb_forward_producer.sv
module tb_forward_producer;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  forward_producer_if #(.WIDTH(W)) bus();
  forward_producer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // Model: each stage holds the instruction record itself (destination, ready
  // stage, issue value and the results observed as it passed E and M). What a
  // stage shows is derived from the instruction's ready stage vs. position.
  typedef struct packed {
    bit [4:0]   rg;
    bit [1:0]   rdy;
    bit [W-1:0] ival;
    bit [W-1:0] eres;
    bit [W-1:0] mres;
  } rec_t;

  rec_t mE, mM, mW;

  function automatic bit [W-1:0] known(rec_t r, int s);
    if (r.rg == 0) return '0;
    case (r.rdy)
      2'd0:    return r.ival;
      2'd1:    return (s >= 1) ? r.eres : '0;
      2'd2:    return (s >= 2) ? r.mres : '0;
      default: return '0;
    endcase
  endfunction

  function automatic bit vis(rec_t r, int s);
    return (r.rg != 0) && (int'(r.rdy) <= s);
  endfunction

  function automatic bit [W-1:0] shown(rec_t r, int s);
    return vis(r, s) ? known(r, s) : '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mE <= '0;
      mM <= '0;
      mW <= '0;
    end else begin
      mW      <= mM;
      mW.mres <= bus.memResult;
      if (bus.stall) mM <= '0;
      else begin
        mM      <= mE;
        mM.eres <= bus.execResult;
      end
      if (bus.flush) mE <= '0;
      else if (bus.stall) mE <= mE;
      else if (bus.issue && bus.issueDestReg != 0)
        mE <= '{rg: bus.issueDestReg, rdy: bus.issueReadyStage,
                ival: bus.issueValue, eres: '0, mres: '0};
      else mE <= '0;
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("src1Valid", 64'(bus.src1Valid), 64'(vis(mE, 0)));
    chk("src1Reg",   64'(bus.src1Reg),   64'(mE.rg));
    chk("src1Value", 64'(bus.src1Value), 64'(shown(mE, 0)));
    chk("src2Valid", 64'(bus.src2Valid), 64'(vis(mM, 1)));
    chk("src2Reg",   64'(bus.src2Reg),   64'(mM.rg));
    chk("src2Value", 64'(bus.src2Value), 64'(shown(mM, 1)));
    chk("src3Valid", 64'(bus.src3Valid), 64'(vis(mW, 2)));
    chk("src3Reg",   64'(bus.src3Reg),   64'(mW.rg));
    chk("src3Value", 64'(bus.src3Value), 64'(shown(mW, 2)));
    chk("wbEnable",  64'(bus.wbEnable),  64'(vis(mW, 2)));
    chk("wbReg",     64'(bus.wbReg),     64'(mW.rg));
    chk("wbValue",   64'(bus.wbValue),   64'(known(mW, 2)));
  end

  // Apply one cycle of inputs and return at the following falling edge.
  task automatic drv(bit iss, bit [4:0] dr, bit [1:0] rs, bit [W-1:0] iv,
                     bit [W-1:0] er, bit [W-1:0] mr, bit st, bit fl);
    bus.issue           = iss;
    bus.issueDestReg    = dr;
    bus.issueReadyStage = rs;
    bus.issueValue      = iv;
    bus.execResult      = er;
    bus.memResult       = mr;
    bus.stall           = st;
    bus.flush           = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    drv(0, 0, 0, '0, '0, '0, 0, 0);
  endtask

  initial begin
    bus.issue = 0; bus.issueDestReg = 0; bus.issueReadyStage = 0;
    bus.issueValue = '0; bus.execResult = '0; bus.memResult = '0;
    bus.stall = 0; bus.flush = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst src1Valid", 64'(bus.src1Valid), 64'd0);
    chk("rst wbEnable",  64'(bus.wbEnable),  64'd0);
    rst_n = 1'b1;

    // ALU op
    drv(1, 5, 1, '0, '0, '0, 0, 0);        #1;
    chk("alu e1 src1Reg",   64'(bus.src1Reg),   64'd5);
    chk("alu e1 src1Valid", 64'(bus.src1Valid), 64'd0);
    drv(0, 0, 0, '0, 32'h11, '0, 0, 0);    #1;
    chk("alu e2 src2Valid", 64'(bus.src2Valid), 64'd1);
    chk("alu e2 src2Value", 64'(bus.src2Value), 64'h11);
    idle();                                 #1;
    chk("alu e3 src3Value", 64'(bus.src3Value), 64'h11);
    chk("alu e3 wbEnable",  64'(bus.wbEnable),  64'd1);
    chk("alu e3 wbReg",     64'(bus.wbReg),     64'd5);
    chk("alu e3 wbValue",   64'(bus.wbValue),   64'h11);

    // Load
    drv(1, 8, 2, '0, '0, '0, 0, 0);        #1;
    chk("ld e1 src1Valid", 64'(bus.src1Valid), 64'd0);
    drv(0, 0, 0, '0, 32'h55, '0, 0, 0);    #1;
    chk("ld e2 src2Valid", 64'(bus.src2Valid), 64'd0);
    chk("ld e2 src2Reg",   64'(bus.src2Reg),   64'd8);
    drv(0, 0, 0, '0, '0, 32'hDEAD, 0, 0);  #1;
    chk("ld e3 src3Valid", 64'(bus.src3Valid), 64'd1);
    chk("ld e3 src3Value", 64'(bus.src3Value), 64'hDEAD);

    // Link
    drv(1, 31, 0, 32'h400008, '0, '0, 0, 0); #1;
    chk("lnk e1 src1Valid", 64'(bus.src1Valid), 64'd1);
    chk("lnk e1 src1Value", 64'(bus.src1Value), 64'h400008);
    drv(0, 0, 0, '0, 32'h99, '0, 0, 0);    #1;
    chk("lnk e2 src2Value", 64'(bus.src2Value), 64'h400008);
    drv(0, 0, 0, '0, '0, 32'h77, 0, 0);    #1;
    chk("lnk e3 wbValue",   64'(bus.wbValue),   64'h400008);

    // Stall: load held in E for two cycles; an issue during stall is ignored
    drv(1, 9, 2, '0, '0, '0, 0, 0);
    drv(1, 12, 0, 32'hC, '0, '0, 1, 0);    #1;
    chk("stl src1Reg",   64'(bus.src1Reg),   64'd9);
    chk("stl src1Valid", 64'(bus.src1Valid), 64'd0);
    chk("stl src2Reg",   64'(bus.src2Reg),   64'd0);
    drv(0, 0, 0, '0, '0, '0, 1, 0);        #1;
    chk("stl2 src1Reg",  64'(bus.src1Reg),   64'd9);
    idle();                                 #1;
    chk("stl adv src2Reg", 64'(bus.src2Reg), 64'd9);
    drv(0, 0, 0, '0, '0, 32'hBEEF, 0, 0);  #1;
    chk("stl W src3Value", 64'(bus.src3Value), 64'hBEEF);

    // Flush + stall + issue with reg 3 in E
    drv(1, 3, 1, '0, '0, '0, 0, 0);
    drv(1, 7, 0, 32'h123, 32'hAB, '0, 1, 1); #1;
    chk("fl src1Reg", 64'(bus.src1Reg), 64'd0);
    chk("fl src2Reg", 64'(bus.src2Reg), 64'd0);
    repeat (3) begin
      idle(); #1;
      chk("fl wbEnable", 64'(bus.wbEnable), 64'd0);
    end

    // Fill all stages, then assert reset between edges
    drv(1, 1, 0, 32'hA1, '0, '0, 0, 0);
    drv(1, 2, 1, '0, '0, '0, 0, 0);
    drv(1, 3, 0, 32'hC3, 32'hB2, '0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst src1Valid", 64'(bus.src1Valid), 64'd0);
    chk("arst src2Valid", 64'(bus.src2Valid), 64'd0);
    chk("arst src3Valid", 64'(bus.src3Valid), 64'd0);
    chk("arst src1Reg",   64'(bus.src1Reg),   64'd0);
    chk("arst src2Value", 64'(bus.src2Value), 64'd0);
    chk("arst wbEnable",  64'(bus.wbEnable),  64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Never-forwardable and no-destination issues
    drv(1, 4, 3, 32'h5, '0, '0, 0, 0);     #1;
    chk("r3 src1Valid", 64'(bus.src1Valid), 64'd0);
    drv(1, 0, 0, 32'h6, 32'h7, '0, 0, 0);  #1;
    chk("r0 src1Valid", 64'(bus.src1Valid), 64'd0);
    chk("r3 src2Valid", 64'(bus.src2Valid), 64'd0);
    idle();                                 #1;
    chk("r3 wbEnable",  64'(bus.wbEnable),  64'd0);
    chk("r3 src3Value", 64'(bus.src3Value), 64'd0);

    // Mixed traffic, checked by the per-cycle model comparison
    for (int i = 0; i < 40; i++) begin
      drv(1'($urandom_range(0, 3) != 0), 5'($urandom), 2'($urandom),
          W'($urandom), W'($urandom), W'($urandom),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
    end
    repeat (4) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
